// File: rtl/butterworth_sched_if.sv
// Channel sample, filtered result and coefficient-configuration bundle of the
// Butterworth scheduler.
interface butterworth_sched_if #(
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]    in_valid;
  logic [32*CHANNELS-1:0] in_data;
  logic [CHANNELS-1:0]    in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [CW-1:0]          out_ch;
  logic [31:0]            out_data;
  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [31:0]            cfg_wdata;
  logic                   cfg_ready;
  logic                   busy;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
    output in_ready, out_valid, out_ch, out_data, cfg_ready, busy
  );

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, out_valid, out_ch, out_data, cfg_ready, busy
  );
endinterface

// File: rtl/butterworth_sched.sv
// First-order Butterworth IIR for several channels: round-robin sample grant,
// then c0*x + c1*x[n-1] + c2*y[n-1] sequenced over one shared multiplier.
module butterworth_sched #(
  parameter int          CHANNELS     = 4,
  parameter int          DECIMAL_BITS = 10,
  parameter logic [31:0] C0_INIT      = 32'h0000_0200,
  parameter logic [31:0] C1_INIT      = 32'h0000_0200,
  parameter logic [31:0] C2_INIT      = 32'h0000_0000
) (
  input logic                CLK,
  input logic                RST_N,
  butterworth_sched_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0, MAC0 = 3'd1, MAC1 = 3'd2, MAC2 = 3'd3, WB = 3'd4, OUT = 3'd5
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CW-1:0]       rr_ptr_r, ch_r, gnt_idx_s, idx_s;
  logic                gnt_found_s, grant_en_r, hs_s;
  logic [CHANNELS-1:0] gnt_onehot_s;
  logic [31:0]         x_r, c0_r, c1_r, c2_r, mul_a_s, mul_b_s, in_sel_s, y_s;
  logic [31:0]         x_past_r [CHANNELS];
  logic [31:0]         y_past_r [CHANNELS];
  logic [63:0]         acc_r, prod_s;
  logic                out_valid_r;
  logic [31:0]         out_data_r;
  logic [CW-1:0]       out_ch_r;

  // Round-robin search starting at rr_ptr; grant_en_r keeps in_ready low while in reset
  always_comb begin
    gnt_found_s  = 1'b0;
    gnt_idx_s    = '0;
    idx_s        = '0;
    gnt_onehot_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx_s = CW'((int'(rr_ptr_r) + k) % CHANNELS);
      if (!gnt_found_s && bus.in_valid[idx_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = idx_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    if (grant_en_r && (state_r == IDLE) && gnt_found_s) begin
      gnt_onehot_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_onehot_s = '0;
    end
  end

  assign hs_s = |gnt_onehot_s;

  // Sample word of the granted channel
  always_comb begin
    in_sel_s = 32'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx_s == CW'(i)) begin
        in_sel_s = bus.in_data[32*i +: 32];
      end else begin
        in_sel_s = in_sel_s;
      end
    end
  end

  // Operand steering for the single shared multiplier
  always_comb begin
    mul_a_s = c0_r;
    mul_b_s = x_r;
    case (state_r)
      MAC1:    begin mul_a_s = c1_r; mul_b_s = x_past_r[ch_r]; end
      MAC2:    begin mul_a_s = c2_r; mul_b_s = y_past_r[ch_r]; end
      default: begin mul_a_s = c0_r; mul_b_s = x_r;            end
    endcase
  end

  // Low 64 bits of the sign-extended product equal the full signed 32x32 product
  assign prod_s = {{32{mul_a_s[31]}}, mul_a_s} * {{32{mul_b_s[31]}}, mul_b_s};
  assign y_s    = acc_r[DECIMAL_BITS +: 32];

  // Next-state sequencing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (hs_s) state_nxt_s = MAC0; else state_nxt_s = IDLE;
      MAC0:    state_nxt_s = MAC1;
      MAC1:    state_nxt_s = MAC2;
      MAC2:    state_nxt_s = WB;
      WB:      state_nxt_s = OUT;
      OUT:     if (bus.out_ready) state_nxt_s = IDLE; else state_nxt_s = OUT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, history, coefficients and registered result
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_en_r  <= 1'b0;
      rr_ptr_r    <= '0;
      ch_r        <= '0;
      x_r         <= 32'd0;
      acc_r       <= 64'd0;
      c0_r        <= C0_INIT;
      c1_r        <= C1_INIT;
      c2_r        <= C2_INIT;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      out_ch_r    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        x_past_r[i] <= 32'd0;
        y_past_r[i] <= 32'd0;
      end
    end else begin
      grant_en_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (bus.cfg_we) begin
            case (bus.cfg_addr)
              2'd0:    c0_r <= bus.cfg_wdata;
              2'd1:    c1_r <= bus.cfg_wdata;
              2'd2:    c2_r <= bus.cfg_wdata;
              default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                  x_past_r[i] <= 32'd0;
                  y_past_r[i] <= 32'd0;
                end
              end
            endcase
          end
          if (hs_s) begin
            x_r      <= in_sel_s;
            ch_r     <= gnt_idx_s;
            rr_ptr_r <= (gnt_idx_s == CW'(CHANNELS - 1)) ? '0 : gnt_idx_s + CW'(1);
          end
        end
        MAC0: acc_r <= prod_s;
        MAC1: acc_r <= acc_r + prod_s;
        MAC2: acc_r <= acc_r + prod_s;
        WB: begin
          x_past_r[ch_r] <= x_r;
          y_past_r[ch_r] <= y_s;
          out_data_r     <= y_s;
          out_ch_r       <= ch_r;
          out_valid_r    <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = gnt_onehot_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.cfg_ready = (state_r == IDLE);
  assign bus.busy      = (state_r != IDLE);
endmodule

// File: tb/tb_butterworth_sched.sv
// Randomized and directed bench for butterworth_sched against a per-sample
// arithmetic model of the filter and its round-robin arbitration.
module tb_butterworth_sched;
  localparam int C  = 4;
  localparam int DB = 10;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  butterworth_sched_if #(.CHANNELS(C)) bus ();

  butterworth_sched #(
    .CHANNELS(C), .DECIMAL_BITS(DB),
    .C0_INIT(32'h0000_0200), .C1_INIT(32'h0000_0200), .C2_INIT(32'h0000_0000)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: coefficients, history, last-granted pointer, cycles since handshake (0 = idle)
  int m_c [3];
  int m_xp [C];
  int m_yp [C];
  int m_rr, m_since, m_pend_y, m_pend_ch, m_out_y, m_out_ch;

  int   cyc = 0, hs_cyc = 0, first_ov_cyc = 0;
  bit   ov_prev = 1'b0;
  bit   hs_seen, acc_seen;
  int   hs_ch, acc_ch;
  logic [31:0]  acc_data;
  logic [C-1:0] obs_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  function automatic int grant(input logic [C-1:0] v, input int rr);
    for (int k = 0; k < C; k++) begin
      if (v[(rr + k) % C]) return (rr + k) % C;
    end
    return -1;
  endfunction

  function automatic int model_y(input int x, input int xp, input int yp);
    longint a;
    a = longint'(m_c[0]) * longint'(x) + longint'(m_c[1]) * longint'(xp)
      + longint'(m_c[2]) * longint'(yp);
    return int'(a >>> DB);
  endfunction

  function automatic logic [32*C-1:0] rand_data();
    logic [32*C-1:0] d;
    for (int i = 0; i < C; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_c[0] = 32'h200; m_c[1] = 32'h200; m_c[2] = 0;
    for (int i = 0; i < C; i++) begin m_xp[i] = 0; m_yp[i] = 0; end
    m_rr = 0; m_since = 0; m_out_y = 0; m_out_ch = 0; ov_prev = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'd0;
    RST_N = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One clock: drive, check every output against the model, then advance the model
  task automatic cycle(input logic [C-1:0] vld, input logic [32*C-1:0] dat, input logic ordy,
                       input logic we, input logic [1:0] addr, input logic [31:0] wd);
    int g, x;
    logic [C-1:0] exp_rdy;
    @(negedge CLK);
    bus.in_valid = vld; bus.in_data = dat; bus.out_ready = ordy;
    bus.cfg_we = we; bus.cfg_addr = addr; bus.cfg_wdata = wd;
    #1;
    g = (m_since == 0) ? grant(vld, m_rr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    chk("busy",      32'(bus.busy),      32'(m_since != 0));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_since == 0));
    chk("out_valid", 32'(bus.out_valid), 32'(m_since == 5));
    chk("out_data",  bus.out_data,       m_out_y);
    chk("out_ch",    32'(bus.out_ch),    m_out_ch);
    if (bus.out_valid && !ov_prev) first_ov_cyc = cyc;
    ov_prev  = bus.out_valid;
    obs_rdy  = bus.in_ready;
    hs_seen  = (g >= 0);
    hs_ch    = g;
    acc_seen = (m_since == 5) && ordy;
    acc_data = bus.out_data;
    acc_ch   = int'(bus.out_ch);
    if (hs_seen) hs_cyc = cyc;
    @(posedge CLK);
    cyc++;
    if (m_since == 0) begin
      if (we) begin
        if (addr == 2'd3) begin
          for (int i = 0; i < C; i++) begin m_xp[i] = 0; m_yp[i] = 0; end
        end else begin
          m_c[addr] = int'(wd);
        end
      end
      if (g >= 0) begin
        x = int'(dat[32*g +: 32]);
        m_pend_y  = model_y(x, m_xp[g], m_yp[g]);
        m_xp[g]   = x;
        m_yp[g]   = m_pend_y;
        m_pend_ch = g;
        m_rr      = (g + 1) % C;
        m_since   = 1;
      end
    end else if (m_since == 5) begin
      if (ordy) m_since = 0;
    end else begin
      m_since++;
      if (m_since == 5) begin m_out_y = m_pend_y; m_out_ch = m_pend_ch; end
    end
  endtask

  task automatic cfg(input logic [1:0] addr, input logic [31:0] wd);
    cycle('0, '0, 1'b1, 1'b1, addr, wd);
  endtask

  task automatic drain();
    int n = 0;
    while (m_since != 0 && n < 30) begin cycle('0, '0, 1'b1, 1'b0, 2'd0, 32'd0); n++; end
    chk("drain_idle", 32'(m_since), 32'd0);
  endtask

  task automatic send(input int ch, input logic [31:0] x, output logic [31:0] y, output int ych);
    logic [32*C-1:0] d;
    logic [C-1:0] v;
    int n;
    d = '0; d[32*ch +: 32] = x;
    v = '0; v[ch] = 1'b1;
    n = 0; hs_seen = 1'b0;
    while (!hs_seen && n < 20) begin cycle(v, d, 1'b1, 1'b0, 2'd0, 32'd0); n++; end
    chk("handshake", 32'(hs_seen), 32'd1);
    n = 0; acc_seen = 1'b0;
    while (!acc_seen && n < 20) begin cycle('0, '0, 1'b1, 1'b0, 2'd0, 32'd0); n++; end
    chk("result_seen", 32'(acc_seen), 32'd1);
    chk("latency", 32'(first_ov_cyc - hs_cyc), 32'd5);
    y = acc_data; ych = acc_ch;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] y;
    int ych, n, ngr;
    int gr [4];
    logic [32*C-1:0] d;

    do_reset();

    // Arbitration from rr_ptr=0 with two requesters held
    ngr = 0; n = 0;
    while (ngr < 4 && n < 60) begin
      cycle(4'b0011, rand_data(), 1'b1, 1'b0, 2'd0, 32'd0);
      if (obs_rdy != '0) begin
        for (int i = 0; i < C; i++) if (obs_rdy[i]) gr[ngr] = i;
        ngr++;
      end
      n++;
    end
    chk("arb_count", 32'(ngr), 32'd4);
    chk("arb_g0", 32'(gr[0]), 32'd0);
    chk("arb_g1", 32'(gr[1]), 32'd1);
    chk("arb_g2", 32'(gr[2]), 32'd0);
    chk("arb_g3", 32'(gr[3]), 32'd1);
    drain();
    send(0, 32'd5, y, ych);
    n = 0; obs_rdy = '0;
    while (obs_rdy == '0 && n < 20) begin cycle(4'b1001, rand_data(), 1'b1, 1'b0, 2'd0, 32'd0); n++; end
    chk("arb_wrap_ch3", 32'(obs_rdy), 32'b1000);
    drain();

    // FIR
    cfg(2'd0, 32'h200); cfg(2'd1, 32'h200); cfg(2'd2, 32'h0); cfg(2'd3, 32'h0);
    send(0, 32'd1024, y, ych); chk("fir_y0", y, 32'd512);  chk("fir_ch", 32'(ych), 32'd0);
    send(0, 32'd2048, y, ych); chk("fir_y1", y, 32'd1536);

    // IIR decay
    cfg(2'd0, 32'h400); cfg(2'd1, 32'h0); cfg(2'd2, 32'h200); cfg(2'd3, 32'h0);
    send(1, 32'd100, y, ych); chk("iir_y0", y, 32'd100); chk("iir_ch", 32'(ych), 32'd1);
    send(1, 32'd0,   y, ych); chk("iir_y1", y, 32'd50);
    send(1, 32'd0,   y, ych); chk("iir_y2", y, 32'd25);

    // Sign, floor rounding, wrap
    cfg(2'd0, 32'h200); cfg(2'd2, 32'h0);
    send(2, 32'hFFFF_FFFD, y, ych); chk("neg_floor", y, 32'hFFFF_FFFE);
    cfg(2'd0, 32'h7FFF_FFFF);
    send(3, 32'h7FFF_FFFF, y, ych); chk("wrap", y, 32'hFFC0_0000);

    // Coefficient write in the same cycle as a grant is used for that sample
    cfg(2'd0, 32'h200); cfg(2'd3, 32'h0);
    d = '0; d[31:0] = 32'd1024;
    cycle(4'b0001, d, 1'b1, 1'b1, 2'd0, 32'h400);
    n = 0; acc_seen = 1'b0;
    while (!acc_seen && n < 20) begin cycle('0, '0, 1'b1, 1'b0, 2'd0, 32'd0); n++; end
    chk("cfg_same_cycle", acc_data, 32'd1024);

    // Backpressure with an ignored write while busy
    cfg(2'd0, 32'h200); cfg(2'd1, 32'h0);
    d = '0; d[64 +: 32] = 32'd1024;
    cycle(4'b0100, d, 1'b0, 1'b0, 2'd0, 32'd0);
    n = 0;
    while (m_since != 5 && n < 20) begin cycle(4'b1111, rand_data(), 1'b0, 1'b1, 2'd0, 32'h400); n++; end
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1111, rand_data(), 1'b0, 1'b1, 2'd0, 32'h400);
      chk("bp_hold_data", acc_data, 32'd512);
      chk("bp_hold_ch", 32'(acc_ch), 32'd2);
    end
    cycle('0, '0, 1'b1, 1'b0, 2'd0, 32'd0);
    send(2, 32'd1024, y, ych); chk("bp_write_ignored", y, 32'd512);
    cfg(2'd0, 32'h400);
    send(2, 32'd1024, y, ych); chk("idle_write_applied", y, 32'd1024);

    // Reset during MAC1
    d = '0; d[31:0] = 32'd1024;
    cycle(4'b0001, d, 1'b1, 1'b0, 2'd0, 32'd0);
    cycle('0, '0, 1'b1, 1'b0, 2'd0, 32'd0);
    do_reset();
    send(0, 32'd1024, y, ych); chk("post_reset", y, 32'd512);

    // Random traffic, backpressure and configuration
    for (int it = 0; it < 1500; it++) begin
      cycle(4'($urandom_range(0, 15)), rand_data(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), $urandom);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
